// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch front end with an in-order
// prefetch queue, credit-based request throttling and redirect flush.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds fetch_fault output and
// traps misaligned redirect targets; otherwise redirect_pc[1:0] is forced to 0).
module inst_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Stale responses can pile up across back-to-back redirects, so the
    // drop counter gets headroom beyond a single queue's worth of credits.
    localparam int unsigned DW = CW + 4;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [DW-1:0] drop_cnt;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [31:0]   mem [DEPTH];
    logic          fault_q;

    logic [31:0]   redir_target;
    logic          redir_bad;
    logic [SW-1:0] inflight;
    logic          req_fire;
    logic          resp_live;
    logic          resp_drop;
    logic          enq;
    logic          deq;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_target = redirect_pc;
    assign redir_bad    = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault  = !rst && fault_q;

    // Fault flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= redir_bad;
        end
    end
`else
    assign redir_target = redirect_pc & ~32'h0000_0003;
    assign redir_bad    = 1'b0;
    assign fault_q      = redir_bad;
`endif

    // Handshake decode and output gating; credits keep the queue from overflowing.
    always_comb begin
        inflight       = SW'(count) + SW'(outstanding);
        imem_req_valid = !rst && !redirect_valid && !fault_q && (inflight < SW'(DEPTH));
        imem_req_addr  = rst ? 32'h0 : fetch_pc;
        inst_valid     = !rst && !fault_q && (count != '0);
        inst           = rst ? 32'h0 : mem[rptr];
        inst_pc        = rst ? 32'h0 : head_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (drop_cnt != '0);
        resp_live      = imem_resp_valid && (drop_cnt == '0);
        enq            = resp_live && !redirect_valid;
        deq            = inst_valid && inst_ready && !redirect_valid;
    end

    // Fetch/queue bookkeeping; redirect overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redir_target;
            head_pc     <= redir_target;
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
            // Every live request becomes stale; a response arriving now is discarded.
            outstanding <= '0;
            drop_cnt    <= DW'(outstanding) + drop_cnt - DW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) begin
                head_pc <= head_pc + 32'd4;
                rptr    <= rptr + PW'(1);
            end
            if (enq) begin
                wptr <= wptr + PW'(1);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            count       <= count + CW'(enq) - CW'(deq);
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);
        end
    end

    // Queue storage: written at the tail on each accepted live response.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a fixed-latency in-order memory model.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_acc    = 0;
    bit          acc_pend = 1'b0;
    logic [31:0] acc_addr = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC3A5_0F96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: accepted requests answer exactly 'lat' cycles later, in order.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mq.delete();
                acc_pend = 1'b0;
            end else if (acc_pend) begin
                mq.push_back('{addr: acc_addr, due: cyc + lat});
                acc_pend = 1'b0;
            end
            cyc++;
            if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mdata(mq[0].addr);
                mq.delete(0);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    // Monitor: compares accepted requests and consumed instructions against queues.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                acc_pend = 1'b1;
                acc_addr = imem_req_addr;
                n_acc++;
                if (exp_req.size() > 0) begin
                    e = exp_req.pop_front();
                    check("req_addr", imem_req_addr, e);
                end
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_pc.size() > 0) begin
                    e = exp_pc.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_data", inst, mdata(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        rst   = 1'b0;
        n_acc = 0;
    endtask

    task automatic finish_test(input string name);
        check({name, "_req_drained"}, 32'(exp_req.size()), 32'd0);
        check({name, "_inst_drained"}, 32'(exp_pc.size()), 32'd0);
        exp_req.delete();
        exp_pc.delete();
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Reset state and first-fetch latency with a 1-cycle memory.
        lat = 1;
        tick();
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        for (int i = 0; i < 8; i++) exp_req.push_back(32'(4 * i));
        for (int i = 0; i < 6; i++) exp_pc.push_back(32'(4 * i));
        do_reset();
        @(negedge clk);
        check("c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("c1_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c2_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c3_inst_valid", 32'(inst_valid), 32'd1);
        ticks(7);
        finish_test("seq");

        // Decode stall: exactly DEPTH requests, then resume without loss.
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) exp_req.push_back(32'(4 * i));
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        check("stall_acc_count", 32'(n_acc), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_inst_pc", inst_pc, 32'h0);
        check("stall_inst_data", inst, mdata(32'h0));
        tick();
        for (int i = 0; i < 5; i++) exp_pc.push_back(32'(4 * i));
        inst_ready = 1'b1;
        ticks(10);
        finish_test("stall");

        // Latency 3: redirect with two stale requests in flight.
        lat = 3;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h100);
        exp_req.push_back(32'h104);
        exp_req.push_back(32'h108);
        exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104);
        exp_pc.push_back(32'h108);
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        ticks(12);
        finish_test("drop");

        // Redirect coinciding with a response and a dequeue attempt.
        lat        = 1;
        inst_ready = 1'b0;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        exp_req.push_back(32'hC);
        exp_req.push_back(32'h40);
        exp_req.push_back(32'h44);
        exp_pc.push_back(32'h40);
        exp_pc.push_back(32'h44);
        do_reset();
        ticks(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_empty_r1", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("flush_empty_r2", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("redir_r3_valid", 32'(inst_valid), 32'd1);
        check("redir_r3_pc", inst_pc, 32'h40);
        ticks(4);
        finish_test("collide");

        // PC wraparound at the top of the address space.
        exp_req.push_back(32'hFFFF_FFF8);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0004);
        exp_pc.push_back(32'hFFFF_FFF8);
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_pc.push_back(32'h0000_0000);
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ticks(8);
        finish_test("wrap");

        // Misaligned redirect target.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fault_set", 32'(fetch_fault), 32'd1);
            check("fault_no_req", 32'(imem_req_valid), 32'd0);
            check("fault_no_inst", 32'(inst_valid), 32'd0);
            tick();
        end
        exp_req.push_back(32'h200);
        exp_req.push_back(32'h204);
        exp_pc.push_back(32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("fault_held_in_redir", 32'(fetch_fault), 32'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("fault_cleared", 32'(fetch_fault), 32'd0);
        ticks(6);
`else
        exp_req.push_back(32'h100);
        exp_req.push_back(32'h104);
        exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104);
        tick();
        redirect_valid = 1'b0;
        ticks(8);
`endif
        finish_test("align");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch front end for `cpu_top`. It issues sequential word fetches to instruction memory and buffers the returned instructions in an in-order prefetch queue. It presents the instructions, each with its PC, to the decode stage over a valid/ready handshake. A redirect from execute (branch or jump) flushes the queue and drops every in-flight memory response.

## Interface
Parameters:
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: word address of the request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_resp_valid` in 1: response strobe; responses arrive in order, ≥1 cycle after their request.
- `imem_resp_data` in 32: instruction word.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch address.
- `inst_valid` out 1: queue head is valid.
- `inst` out 32: instruction at queue head.
- `inst_pc` out 32: PC of `inst`.
- `inst_ready` in 1: decode consumes the head.
- `fetch_fault` out 1: present only with `FETCH_ALIGN_CHECK_EN` (see Configuration).

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `head_pc`: PC of the queue head.
  - `outstanding`: accepted requests with no response yet, 0..DEPTH.
  - `drop_cnt`: responses still to discard.
  - Queue read and write pointers plus `count`.
- A request is accepted on `imem_req_valid && imem_req_ready`. On acceptance, `fetch_pc += 4` and `outstanding++`.
- `imem_req_valid` = !rst && !redirect_valid && (count + outstanding < DEPTH). This credit rule means the queue can never overflow.
- `imem_req_addr` = `fetch_pc`. It is held stable while valid && !ready.
- Handling of each response (`outstanding--`):
  - If `drop_cnt != 0`, the response is discarded and `drop_cnt--`.
  - Otherwise it is written to the queue tail.
- Dequeue happens on `inst_valid && inst_ready`. It advances the read pointer and sets `head_pc += 4`.
- Redirect (priority over every other event in the same cycle):
  - The queue is flushed: count=0, pointers=0.
  - `fetch_pc` and `head_pc` are set to `redirect_pc`.
  - `drop_cnt` is set to `outstanding + drop_cnt` minus any response arriving in that same cycle, which is itself discarded.
  - A simultaneous dequeue is ignored.
  - No request is issued in the redirect cycle.
- Full and empty conditions:
  - Queue full with decode stalled: requests stop once `count + outstanding == DEPTH`.
  - Empty queue: `inst_valid` = 0. There is no bypass from response to output.
- Arithmetic: PCs are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- All outputs are 0 while `rst` is high. `inst_valid`, `imem_req_valid`, and `fetch_fault` are registered or derived from registers.
- After reset, `fetch_pc` and `head_pc` = `RESET_PC`. `imem_req_valid` rises in the first cycle after `rst` falls.
- Reset mid-operation:
  - Reset discards queue contents and clears `outstanding` and `drop_cnt`.
  - Responses to pre-reset requests are the memory's responsibility. They are reset together with it.
- Latency, with a 1-cycle memory:
  - Request accepted in cycle N.
  - Response in N+1.
  - `inst_valid` in N+2.
- Redirect in cycle R with an immediate ready: request at R+1, and `inst_valid` with `inst_pc = redirect_pc` at R+3 at the earliest.
- Steady state sustains one instruction per cycle when DEPTH ≥ memory latency + 1.
- `inst` and `inst_pc` are held stable while `inst_valid && !inst_ready`.

## Configuration
- Macro `FETCH_ALIGN_CHECK_EN`.
- Defined: the `fetch_fault` port exists.
  - A redirect with `redirect_pc[1:0] != 0` flushes as normal, then sets `fetch_fault` = 1 from the next cycle.
  - While the fault is set, `imem_req_valid` is held 0 and `inst_valid` stays 0.
  - `fetch_fault` clears only on a later aligned redirect or on `rst`.
- Undefined: the port is absent, `redirect_pc[1:0]` is ignored (forced to 0), and fetch always proceeds.

## Test plan
- Reset release with always-ready 1-cycle memory and `inst_ready` = 1 → requests to 0,4,8,… on consecutive cycles; `inst_pc` 0,4,8 with `inst_valid` from the 3rd cycle after reset release.
- `inst_ready` = 0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, then `imem_req_valid` stays 0. Raising ready yields PCs 0,4,8,12 without loss, and fetching resumes.
- Memory latency 3, redirect to 32'h100 while 2 requests are outstanding → both stale responses are dropped; the first `inst_pc` after the redirect is 32'h100 with its data.
- Redirect in the same cycle as a response and as `inst_ready` → the response is discarded, the head is not counted as consumed, and the queue is empty next cycle.
- Redirect to 32'hFFFF_FFF8 → requests at FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With the macro defined, redirect to 32'h102 → `fetch_fault` = 1 and no requests; a later redirect to 32'h200 clears the fault and fetches 32'h200.
